// File: rtl/adder_share_arb_pkg.sv
// Shared constants for the adder-sharing arbiter: adder style names, lookahead
// group size and the requester-index width helper.
package adder_share_arb_pkg;

    localparam string       ST_HYBIRD = "hybird";
    localparam string       ST_BK     = "bk";
    localparam int unsigned CLA_GROUP = 4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/cla_BK.sv
// Brent-Kung parallel-prefix adder; carry-in is folded in as prefix position 0.
module cla_BK #(
    parameter int unsigned NUM = 32
) (
    input  logic [NUM-1:0] a,
    input  logic [NUM-1:0] b,
    input  logic           ci,
    output logic [NUM-1:0] s,
    output logic           co
);

    localparam int unsigned M   = NUM + 1;
    localparam int unsigned TOP = 32'(1) << $clog2(M);

    logic [M-1:0] w_carry;

    always_comb begin
        logic [M-1:0] g;
        logic [M-1:0] p;
        g = {a & b, ci};
        p = {a ^ b, 1'b0};
        for (int d = 1; d < int'(M); d = d * 2) begin
            for (int i = 2 * d - 1; i < int'(M); i += 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        // Down-sweep fills in the prefixes the up-sweep tree skipped.
        for (int d = int'(TOP); d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < int'(M); i += 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        w_carry = g;
    end

    assign s  = (a ^ b) ^ w_carry[NUM-1:0];
    assign co = w_carry[NUM];

endmodule

// File: rtl/cla_Hybird.sv
// Hybrid carry-lookahead adder: lookahead inside 4-bit groups, group carries
// chained through each group's generate/propagate.
module cla_Hybird
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned NUM = 32
) (
    input  logic [NUM-1:0] a,
    input  logic [NUM-1:0] b,
    input  logic           ci,
    output logic [NUM-1:0] s,
    output logic           co
);

    logic [NUM-1:0] w_g;
    logic [NUM-1:0] w_p;
    logic [NUM:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        logic grp_c;
        logic grp_g;
        logic grp_p;
        w_c   = '0;
        grp_c = ci;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int base = 0; base < int'(NUM); base += int'(CLA_GROUP)) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = base; (j < base + int'(CLA_GROUP)) && (j < int'(NUM)); j++) begin
                w_c[j] = grp_g | (grp_p & grp_c);
                grp_g  = w_g[j] | (w_p[j] & grp_g);
                grp_p  = grp_p & w_p[j];
            end
            grp_c = grp_g | (grp_p & grp_c);
        end
        w_c[NUM] = grp_c;
    end

    assign s  = w_p ^ w_c[NUM-1:0];
    assign co = w_c[NUM];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter
    import adder_share_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] w_req_hi;

    always_comb begin
        w_req_hi = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_req_hi[i] = req[i] && (IDW'(i) >= ptr);
        end
    end

    // Requests at/after ptr take priority; otherwise wrap to the lowest index.
    always_comb begin
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (en && !found && w_req_hi[i]) begin
                gnt[i] = 1'b1;
                idx    = IDW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (en && !found && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IDW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Time-shares one carry-lookahead adder among NREQ requesters with round-robin
// arbitration; the winner's result lands in a single tagged output register.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter  int unsigned NUM  = 32,
    parameter  int unsigned NREQ = 4,
    parameter  string       ST   = "hybird",
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*NUM-1:0] req_a,
    input  logic [NREQ*NUM-1:0] req_b,
    input  logic [NREQ-1:0]     req_sub,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [NUM-1:0]      rsp_s,
    output logic                rsp_co
);

    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [NUM-1:0]  r_s;
    logic            r_co;
    logic            r_valid;

    logic            w_accept;
    logic            w_fire;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [NUM-1:0]  w_a;
    logic [NUM-1:0]  w_b;
    logic [NUM-1:0]  w_b_eff;
    logic            w_sub;
    logic [NUM-1:0]  w_sum;
    logic            w_co;

    assign w_accept = !r_valid || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (w_accept),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign req_ready = w_gnt;
    assign w_fire    = |w_gnt;
    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

    // Index-driven operand mux.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sub = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_idx == IDW'(i)) begin
                w_a   = req_a[i*NUM +: NUM];
                w_b   = req_b[i*NUM +: NUM];
                w_sub = req_sub[i];
            end
        end
    end

    // Subtract as A + ~B + 1, with the +1 entering through carry-in.
    assign w_b_eff = w_sub ? ~w_b : w_b;

    generate
        if (ST == ST_HYBIRD) begin : g_hybird
            cla_Hybird #(.NUM(NUM)) u_cla (
                .a  (w_a),
                .b  (w_b_eff),
                .ci (w_sub),
                .s  (w_sum),
                .co (w_co)
            );
        end else begin : g_bk
            cla_BK #(.NUM(NUM)) u_cla (
                .a  (w_a),
                .b  (w_b_eff),
                .ci (w_sub),
                .s  (w_sum),
                .co (w_co)
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_id    <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_ptr <= w_ptr_nxt;
                r_id  <= w_idx;
                r_s   <= w_sum;
                r_co  <= w_co;
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_s     = r_s;
    assign rsp_co    = r_co;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios then random
// traffic against a behavioural round-robin/arithmetic model, both adder styles.
module tb_adder_share_arb;

    localparam int NUM  = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*NUM-1:0] req_a;
    logic [NREQ*NUM-1:0] req_b;
    logic [NREQ-1:0]     req_sub;
    logic                rsp_ready;

    logic [NREQ-1:0] req_ready, req_ready_bk;
    logic            rsp_valid, rsp_valid_bk;
    logic [IDW-1:0]  rsp_id, rsp_id_bk;
    logic [NUM-1:0]  rsp_s, rsp_s_bk;
    logic            rsp_co, rsp_co_bk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int             m_ptr;
    bit             m_valid;
    logic [NUM-1:0] m_s;
    logic           m_co;
    int             m_id;
    int             last_win;

    always #5 clk = ~clk;

    adder_share_arb #(.NUM(NUM), .NREQ(NREQ), .ST("hybird")) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co)
    );

    adder_share_arb #(.NUM(NUM), .NREQ(NREQ), .ST("bk")) dut_bk (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_bk),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid_bk),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id_bk), .rsp_s(rsp_s_bk), .rsp_co(rsp_co_bk)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_s = '0; m_co = 0; m_id = 0; last_win = -1;
    endtask

    task automatic check_rsp();
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("rsp_s",     64'(rsp_s),     64'(m_s));
        chk("rsp_co",    64'(rsp_co),    64'(m_co));
        chk("rsp_id",    64'(rsp_id),    64'(m_id));
        chk("bk_rsp_valid", 64'(rsp_valid_bk), 64'(m_valid));
        chk("bk_rsp_s",     64'(rsp_s_bk),     64'(m_s));
        chk("bk_rsp_co",    64'(rsp_co_bk),    64'(m_co));
        chk("bk_rsp_id",    64'(rsp_id_bk),    64'(m_id));
    endtask

    // One clock: check grant before the edge, advance the model, check result after.
    task automatic cycle();
        bit              acc;
        int              w;
        logic [NREQ-1:0] exp_rdy;
        logic [NUM-1:0]  a, b;
        logic            sub;
        logic [NUM:0]    sum;
        @(negedge clk);
        acc = !m_valid || rsp_ready;
        w = -1;
        a = '0; b = '0; sub = 1'b0;
        if (acc) begin
            for (int k = 0; k < NREQ; k++) begin
                int p;
                p = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[p]) w = p;
            end
        end
        exp_rdy = '0;
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            a   = req_a[w*NUM +: NUM];
            b   = req_b[w*NUM +: NUM];
            sub = req_sub[w];
        end
        chk("req_ready",    64'(req_ready),    64'(exp_rdy));
        chk("bk_req_ready", 64'(req_ready_bk), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (acc) begin
            if (w >= 0) begin
                if (sub) begin
                    m_s  = a - b;
                    m_co = (a >= b);
                end else begin
                    sum  = {1'b0, a} + {1'b0, b};
                    m_s  = sum[NUM-1:0];
                    m_co = sum[NUM];
                end
                m_id    = w;
                m_ptr   = (w + 1) % NREQ;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        last_win = w;
        check_rsp();
    endtask

    function automatic logic [NUM-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return NUM'(1);
            default: return NUM'($urandom());
        endcase
    endfunction

    task automatic set_op(input int i, input logic [NUM-1:0] a, input logic [NUM-1:0] b, input logic sub);
        req_a[i*NUM +: NUM] = a;
        req_b[i*NUM +: NUM] = b;
        req_sub[i]          = sub;
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_rsp();
        chk("reset_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1; rst = 1'b0;

        // Single add with carry-out
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        cycle();
        chk("add_s",  64'(rsp_s),  64'(0));
        chk("add_co", 64'(rsp_co), 64'(1));
        chk("add_id", 64'(rsp_id), 64'(2));
        req_valid = '0;

        // Subtract with and without borrow
        req_valid = 4'b0001;
        set_op(0, 32'h5, 32'h7, 1'b1);
        cycle();
        chk("sub_borrow_s",  64'(rsp_s),  64'(32'hFFFF_FFFE));
        chk("sub_borrow_co", 64'(rsp_co), 64'(0));
        set_op(0, 32'h7, 32'h5, 1'b1);
        cycle();
        chk("sub_s",  64'(rsp_s),  64'(2));
        chk("sub_co", 64'(rsp_co), 64'(1));
        req_valid = '0;

        // Async reset while a result is pending
        req_valid = 4'b0010;
        set_op(1, 32'h2, 32'h3, 1'b0);
        cycle();
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("pre_rst_s", 64'(rsp_s), 64'(5));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_rsp();
        chk("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1; rst = 1'b0;

        // Round robin with all requesters continuously valid
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_id",    64'(rsp_id),    64'(k % NREQ));
            chk("rr_valid", 64'(rsp_valid), 64'(1));
            if (last_win >= 0) set_op(last_win, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
        req_valid = '0;

        // Backpressure: result held, nothing granted, then regrant on release
        req_valid = 4'b0010;
        set_op(1, 32'h1000, 32'h234, 1'b0);
        cycle();
        chk("bp_first", 64'(rsp_s), 64'(32'h1234));
        req_valid = 4'b1000;
        set_op(3, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_s",   64'(rsp_s),     64'(32'h1234));
            chk("bp_hold_rdy", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_regrant", 64'(req_ready), 64'(4'b1000));
        cycle();
        chk("bp_next_id", 64'(rsp_id), 64'(3));
        req_valid = '0;

        // Idle drain: valid falls, pointer is untouched by idle cycles
        cycle();
        chk("drain_valid", 64'(rsp_valid), 64'(0));
        cycle();
        cycle();
        req_valid = '1;
        #1;
        chk("idle_ptr", 64'(req_ready), 64'(4'b0001));
        cycle();
        req_valid = '0;
        cycle();

        // Random traffic with random consumer backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_win >= 0) req_valid[last_win] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter that time-shares one carry-lookahead adder among NREQ requesters (e.g. ALU, AGU, branch-target unit). Each requester presents an add/subtract operation on a valid/ready handshake. The winner's operands go through the adder and the result is captured in a single output register, tagged with the requester index. The block sits in the backend between issue logic and the shared `cla_Hybird`/`cla_BK` instance.

## Interface
- NUM, 32, operand/result width
- NREQ, 4, number of requesters (≥1)
- ST, "hybird", adder style: "hybird" selects `cla_Hybird`, anything else selects `cla_BK`
- IDW (localparam): max(1, clog2(NREQ))

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*NUM  operand A, requester i at bits [i*NUM +: NUM]
- req_b  in  NREQ*NUM  operand B, same packing
- req_sub  in  NREQ  1 = A−B, 0 = A+B
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that produced result
- rsp_s  out  NUM  sum/difference
- rsp_co  out  1  adder carry-out

## Operation
- Reset values: rsp_valid=0, rsp_s=0, rsp_id=0, rsp_co=0, rr pointer ptr=0. A result pending at reset is discarded.
- accept = !rsp_valid | rsp_ready.
- When accept=1 and any req_valid is set, the winner is the first set req_valid at or after ptr, searching ascending with wrap. req_ready[winner]=1 in that cycle. All other req_ready bits are 0. When accept=0, all req_ready bits are 0.
- req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready. It never depends on req_a, req_b or req_sub.
- On a transfer (req_valid[w] & req_ready[w]):
  - ptr ← (w+1) mod NREQ.
  - rsp_s ← A + (sub ? ~B : B) + sub, computed mod 2^NUM.
  - rsp_co ← carry out of bit NUM−1. For subtract, co=1 means no borrow.
  - rsp_id ← w.
  - rsp_valid ← 1.
- When accept=1 and no request is valid: rsp_valid ← 0, and ptr and data registers hold.
- When rsp_valid=1 and rsp_ready=0: all outputs hold stable and no request is granted.
- Requesters must hold req_a, req_b and req_sub stable while req_valid=1 and not yet granted. A requester must not drop req_valid before its grant.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- NREQ=1: ptr stays 0, rsp_id=0, and the arbiter degenerates to a pass-through register.

## Timing
- Latency: 1 cycle. A request granted in cycle n produces rsp_valid=1 with its data in cycle n+1.
- Throughput: 1 result per cycle while rsp_ready=1. Simultaneous rsp-pop and new grant in the same cycle has no bubble.
- The adder path is combinational from the muxed operands to the result register. There is no internal pipelining.
- Asynchronous rst clears state immediately, independent of clk. Deassertion is synchronised externally.

## Structure
- Shared header: the ST encoding strings and the IDW clog2 helper function.
- Sub-module `rr_arbiter` (NREQ param): inputs req, ptr and en; outputs one-hot gnt and binary index. This block instantiates it once.
- Adder: one instance of `cla_Hybird` or `cla_BK`, chosen by a generate on ST. ci is driven by the granted req_sub and co is connected.
- Operand mux (NREQ:1, index-driven) and inversion of B sit in this block.

## Test plan
- Reset: assert rst mid-result (rsp_valid=1, rsp_s=0x5) → all outputs 0 immediately, ptr=0. After release, the first grant goes to the lowest valid index.
- Single add: req 2 with A=0xFFFFFFFF, B=0x1, sub=0, rsp_ready=1 → req_ready=0b0100 in cycle n. In n+1: rsp_s=0x0, rsp_co=1, rsp_id=2.
- Subtract: req 0 with A=0x5, B=0x7, sub=1 → rsp_s=0xFFFFFFFE, rsp_co=0. Repeat with A=7, B=5 → rsp_s=0x2, rsp_co=1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with result 0x1234 pending → rsp_* stable, req_ready=0. When rsp_ready rises, a new grant occurs in the same cycle and the next result appears the following cycle.
- Idle drain: one request, then req_valid=0 with rsp_ready=1 → rsp_valid returns to 0 one cycle after the pop, and ptr is unchanged by the idle cycles.
